mantessa_select_pipe: RTL

MANTESSA_SELECT_PIPE -- requirements
Module: mantessa_select_pipe

---
 rtl/mantessa_select_pipe_if.sv | 37 +++
 rtl/mantessa_select_pipe.sv | 122 ++++++++++++
 2 files changed

// File: rtl/mantessa_select_pipe_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module  : mantessa_select_pipe_if
//  Brief   : Valid/ready input and output beats of the mantissa select pipe.
//  Revision: 1.0  initial release
// ============================================================================
interface mantessa_select_pipe_if #(
    parameter int MANT_W    = 24,
    parameter int EXP_W     = 8,
    parameter int OVF_CNT_W = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [MANT_W-1:0]    left_path;
    logic [MANT_W-1:0]    right_path;
    logic [2:0]           adder_top;
    logic [EXP_W-1:0]     exp_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [MANT_W-1:0]    mant_out;
    logic [EXP_W-1:0]     exp_out;
    logic                 ovf_out;
    logic                 lzc_req;
    logic [OVF_CNT_W-1:0] ovf_count;

    modport master (
        output in_valid, left_path, right_path, adder_top, exp_in, out_ready,
        input  in_ready, out_valid, mant_out, exp_out, ovf_out, lzc_req, ovf_count
    );

    modport slave (
        input  in_valid, left_path, right_path, adder_top, exp_in, out_ready,
        output in_ready, out_valid, mant_out, exp_out, ovf_out, lzc_req, ovf_count
    );
endinterface
`default_nettype wire

// File: rtl/mantessa_select_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module  : mantessa_select_pipe
//  Brief   : Two-stage post-add mantissa/exponent selection with overflow
//            saturation to infinity and a saturating overflow event counter.
//  Revision: 1.0  initial release
// ============================================================================
module mantessa_select_pipe #(
    parameter int MANT_W    = 24,
    parameter int EXP_W     = 8,
    parameter int OVF_CNT_W = 8
) (
    input  wire logic              clk,
    input  wire logic              rst,
    mantessa_select_pipe_if.slave  bus
);

    // Incremented exponent at or above all-ones means the left path overflowed.
    localparam logic [EXP_W:0]     c_exp_max = {1'b0, {EXP_W{1'b1}}};
    localparam logic [OVF_CNT_W-1:0] c_cnt_max = {OVF_CNT_W{1'b1}};

    // Stage 1 registers
    logic                 r_s1_valid;
    logic                 r_s1_left;
    logic                 r_s1_lzc;
    logic [MANT_W-1:0]    r_s1_mant;
    logic [EXP_W:0]       r_s1_exp_sum;

    // Stage 2 (output) registers
    logic                 r_s2_valid;
    logic [MANT_W-1:0]    r_s2_mant;
    logic [EXP_W-1:0]     r_s2_exp;
    logic                 r_s2_ovf;
    logic                 r_s2_lzc;
    logic [OVF_CNT_W-1:0] r_ovf_count;

    logic                 w_s2_free;
    logic                 w_s1_move;
    logic                 w_in_ready;
    logic                 w_accept;
    logic                 w_consume;
    logic                 w_sel_left;
    logic                 w_lzc;
    logic [MANT_W-1:0]    w_mant_sel;
    logic [EXP_W:0]       w_exp_sum;
    logic                 w_ovf;
    logic [MANT_W-1:0]    w_mant_res;
    logic [EXP_W-1:0]     w_exp_res;

    // Handshake: S2 may load when empty or being drained this cycle.
    assign w_s2_free  = !r_s2_valid || bus.out_ready;
    assign w_s1_move  = r_s1_valid && w_s2_free;
    assign w_in_ready = !rst && (!r_s1_valid || w_s2_free);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_consume  = r_s2_valid && bus.out_ready;

    // Stage 1 decision
    assign w_sel_left = bus.adder_top[2];
    assign w_lzc      = (bus.adder_top[2:1] == 2'b00);
    assign w_mant_sel = w_sel_left ? bus.left_path : bus.right_path;
    assign w_exp_sum  = {1'b0, bus.exp_in} + {{EXP_W{1'b0}}, w_sel_left};

    // Stage 2 overflow resolve; only the left path can raise the exponent.
    assign w_ovf      = r_s1_left && (r_s1_exp_sum >= c_exp_max);
    assign w_mant_res = w_ovf ? {MANT_W{1'b0}} : r_s1_mant;
    assign w_exp_res  = w_ovf ? {EXP_W{1'b1}} : r_s1_exp_sum[EXP_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid   <= 1'b0;
            r_s1_left    <= 1'b0;
            r_s1_lzc     <= 1'b0;
            r_s1_mant    <= '0;
            r_s1_exp_sum <= '0;
        end else if (w_in_ready) begin
            r_s1_valid <= bus.in_valid;
            if (w_accept) begin
                r_s1_left    <= w_sel_left;
                r_s1_lzc     <= w_lzc;
                r_s1_mant    <= w_mant_sel;
                r_s1_exp_sum <= w_exp_sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_mant  <= '0;
            r_s2_exp   <= '0;
            r_s2_ovf   <= 1'b0;
            r_s2_lzc   <= 1'b0;
        end else if (w_s2_free) begin
            r_s2_valid <= r_s1_valid;
            if (w_s1_move) begin
                r_s2_mant <= w_mant_res;
                r_s2_exp  <= w_exp_res;
                r_s2_ovf  <= w_ovf;
                r_s2_lzc  <= r_s1_lzc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf_count <= '0;
        end else if (w_consume && r_s2_ovf && (r_ovf_count != c_cnt_max)) begin
            r_ovf_count <= r_ovf_count + 1'b1;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_s2_valid;
    assign bus.mant_out  = r_s2_mant;
    assign bus.exp_out   = r_s2_exp;
    assign bus.ovf_out   = r_s2_ovf;
    assign bus.lzc_req   = r_s2_lzc;
    assign bus.ovf_count = r_ovf_count;

endmodule
`default_nettype wire
